// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered in-order issue of ALU requests with fixed-latency result capture.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    output logic [3:0]               alu_opcode,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    input  logic [15:0]              alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_result,
    output logic [3:0]               out_opcode,
    output logic                     out_illegal,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT) + 1;
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT0 = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_mem_op [DEPTH];
    logic [15:0]   r_mem_a  [DEPTH];
    logic [15:0]   r_mem_b  [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cur_op;
    logic          r_cur_ill;
    logic          w_push, w_issue, w_ill;
    logic [3:0]    w_head_op;

    assign w_head_op  = r_mem_op[r_rd];
    assign w_ill      = (w_head_op == 4'b0111) || (w_head_op[3:2] == 2'b11 && w_head_op != 4'b1111);
    assign in_ready   = r_count < FULL;
    assign w_push     = in_valid && in_ready;
    assign w_issue    = (r_count != '0) && (r_state == IDLE || (r_state == HOLD && out_ready));
    assign busy       = (r_state != IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_issue ? WAIT : IDLE;
            WAIT:    w_next = (r_cnt == '0) ? HOLD : WAIT;
            HOLD:    w_next = out_ready ? (w_issue ? WAIT : IDLE) : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr] <= in_opcode;
            r_mem_a[r_wr]  <= in_a;
            r_mem_b[r_wr]  <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_cnt       <= '0;
            r_cur_op    <= '0;
            r_cur_ill   <= 1'b0;
            alu_opcode  <= 4'b1111;
            alu_a       <= '0;
            alu_b       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_opcode  <= '0;
            out_illegal <= 1'b0;
        end else begin
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_issue);
            if (w_push) r_wr <= r_wr + AW'(1);
            // Illegal opcodes reach the ALU as CLEAR; the original opcode travels with the result.
            if (w_issue) begin
                r_rd       <= r_rd + AW'(1);
                alu_opcode <= w_ill ? 4'b1111 : w_head_op;
                alu_a      <= r_mem_a[r_rd];
                alu_b      <= r_mem_b[r_rd];
                r_cur_op   <= w_head_op;
                r_cur_ill  <= w_ill;
                r_cnt      <= CNT0;
            end
            if (r_state == WAIT) begin
                if (r_cnt == '0) begin
                    out_valid   <= 1'b1;
                    out_result  <= alu_result;
                    out_opcode  <= r_cur_op;
                    out_illegal <= r_cur_ill;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
            if (r_state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench with a one-register behavioural ALU.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [3:0]  in_opcode, alu_opcode, out_opcode;
    logic [15:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   hs_cyc[$];
    int   checks = 0, errors = 0, cyc = 0, hs_n = 0, hs_base = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_illegal(out_illegal), .busy(busy), .fifo_count(fifo_count)
    );

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return ~a;
            4'h3:    return a ^ b;
            4'h4:    return ~(a & b);
            4'h5:    return ~(a | b);
            4'h6:    return ~(a ^ b);
            4'h8:    return a + b;
            4'h9:    return a - b;
            4'hA:    return a >> 1;
            4'hB:    return a << 1;
            default: return 16'h0000;
        endcase
    endfunction

    // With alu_* held between issues, one register stage yields a valid result at issue + LAT edges.
    always_ff @(posedge clk) alu_result <= ref_alu(alu_opcode, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int   n = 0;
        exp_t e;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(in_ready), 32'd1);
        e.ill = (op == 4'h7) || (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
        e.op  = op;
        e.res = e.ill ? 16'h0000 : ref_alu(op, a, b);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst && out_valid && out_ready) begin
                    chk("unexpected_result", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        chk("out_result", 32'(out_result), 32'(m_e.res));
                        chk("out_opcode", 32'(out_opcode), 32'(m_e.op));
                        chk("out_illegal", 32'(out_illegal), 32'(m_e.ill));
                        hs_cyc.push_back(cyc);
                        hs_n++;
                    end
                end
            end
        join_none

        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) step();
        chk("rst_alu_opcode", 32'(alu_opcode), 32'hF);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_result", 32'(out_result), 32'h0);
        chk("rst_out_opcode", 32'(out_opcode), 32'h0);
        chk("rst_out_illegal", 32'(out_illegal), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        push(4'h8, 16'h0002, 16'h0003);
        chk("add_count", 32'(fifo_count), 32'd1);
        step();
        chk("add_alu_opcode", 32'(alu_opcode), 32'h8);
        chk("add_alu_a", 32'(alu_a), 32'h2);
        chk("add_alu_b", 32'(alu_b), 32'h3);
        chk("add_busy", 32'(busy), 32'h1);
        repeat (LAT) begin
            chk("add_early_valid", 32'(out_valid), 32'h0);
            step();
        end
        chk("add_valid", 32'(out_valid), 32'h1);
        step();
        chk("add_valid_cleared", 32'(out_valid), 32'h0);
        chk("add_idle", 32'(busy), 32'h0);
        drain();

        hs_cyc.delete();
        push(4'h9, 16'h0002, 16'h0003);
        push(4'h0, 16'hC001, 16'h8001);
        push(4'hB, 16'h0002, 16'h0000);
        drain();
        chk("order_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            chk("order_spacing1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(LAT + 1));
            chk("order_spacing2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(LAT + 1));
        end
        step();

        out_ready = 1'b0;
        hs_base   = hs_n;
        push(4'h0, 16'h00FF, 16'h0F0F);
        push(4'h1, 16'h1200, 16'h0034);
        push(4'h3, 16'hAAAA, 16'h5555);
        push(4'h5, 16'h0F00, 16'h00F0);
        push(4'hA, 16'h8000, 16'h0000);
        in_valid = 1'b1; in_opcode = 4'h6; in_a = 16'h1234; in_b = 16'h1234;
        repeat (2) step();
        chk("bp_fifo_count", 32'(fifo_count), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_opcode", 32'(out_opcode), 32'h0);
        chk("bp_busy", 32'(busy), 32'h1);
        out_ready = 1'b1;
        push(4'h6, 16'h1234, 16'h1234);
        drain();
        chk("bp_result_count", 32'(hs_n - hs_base), 32'd6);
        repeat (2) step();
        chk("bp_no_extra", 32'(out_valid), 32'h0);

        push(4'h7, 16'h1234, 16'h0000);
        step();
        chk("ill_alu_opcode", 32'(alu_opcode), 32'hF);
        chk("ill_alu_a", 32'(alu_a), 32'h1234);
        drain();
        step();

        out_ready = 1'b0;
        push(4'h8, 16'h0010, 16'h0001);
        push(4'h8, 16'h0020, 16'h0002);
        push(4'h8, 16'h0030, 16'h0003);
        push(4'h8, 16'h0040, 16'h0004);
        push(4'h8, 16'h0050, 16'h0005);
        chk("mid_count", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        step();
        chk("mid_wait_count", 32'(fifo_count), 32'd3);
        chk("mid_wait_valid", 32'(out_valid), 32'h0);
        chk("mid_wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        in_valid = 1'b1; in_opcode = 4'h1; in_a = 16'h5A5A; in_b = 16'h0101;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_alu_opcode", 32'(alu_opcode), 32'hF);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (10) begin
            step();
            chk("post_rst_no_result", 32'(out_valid), 32'h0);
        end
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
